// File: rtl/cmac_gt_reset_pkg.sv
// Shared types and constants for the CMAC GT reset sequencer.
package cmac_gt_reset_pkg;

    // Width of the saturating timeout/retry counter.
    localparam int RETRY_W = 4;

    // Sequencer states. The encodings are visible on state_out for debug.
    typedef enum logic [2:0] {
        ST_WAIT_PG    = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_ASSERT_RST = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_READY      = 3'd4,
        ST_FAIL       = 3'd5
    } gt_rst_state_e;

    // Largest of three cycle counts; this sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer for a level signal that is
// asynchronous to clk. The stages are cleared by the synchronous reset.
module cdc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cmac_gt_reset_seq.sv
// Reset sequencer for the CMAC GT quad. Holds the transceiver and the CMAC
// core in reset until power-good has been stable, pulses the GT reset-all,
// then waits for TX/RX reset-done with timeout and bounded retry.
module cmac_gt_reset_seq
    import cmac_gt_reset_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int SETTLE_CYCLES    = 1024,
    parameter int RST_PULSE_CYCLES = 64,
    parameter int TIMEOUT_CYCLES   = 1048576,
    parameter int MAX_RETRIES      = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gt_powergood_in,
    input  logic               tx_reset_done_in,
    input  logic               rx_reset_done_in,
    output logic               gt_reset_all_out,
    output logic               cmac_reset_out,
    output logic               gt_ready_out,
    output logic               timeout_pulse_out,
    output logic [RETRY_W-1:0] retry_count_out,
    output logic [2:0]         state_out
);

    localparam int CNT_MAX = max3(SETTLE_CYCLES, RST_PULSE_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT    = {RETRY_W{1'b1}};

    logic pg_s;
    logic txd_s;
    logic rxd_s;
    logic link_ok_s;
    logic [RETRY_W-1:0] retry_inc_s;

    gt_rst_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pulse_d;
    logic               gt_reset_all_q;
    logic               cmac_reset_q;
    logic               gt_ready_q;
    logic               pulse_q;

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pg (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (gt_powergood_in),
        .q_o   (pg_s)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_txd (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (tx_reset_done_in),
        .q_o   (txd_s)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rxd (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rx_reset_done_in),
        .q_o   (rxd_s)
    );

    assign link_ok_s   = pg_s & txd_s & rxd_s;
    assign retry_inc_s = (retry_q == RETRY_SAT) ? retry_q : (retry_q + RETRY_W'(1));

    // Next-state decode; the counter clears on every transition and counts
    // only while a timed phase is still running.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        retry_d = retry_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_WAIT_PG: begin
                if (pg_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_WAIT_PG;
                end
            end
            ST_SETTLE: begin
                if (!pg_s) begin
                    state_d = ST_WAIT_PG;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_ASSERT_RST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ASSERT_RST: begin
                if (!pg_s) begin
                    state_d = ST_WAIT_PG;
                end else if (cnt_q == PULSE_LAST) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                // Done is tested before the timeout so a coincident done wins.
                if (!pg_s) begin
                    state_d = ST_WAIT_PG;
                end else if (txd_s && rxd_s) begin
                    state_d = ST_READY;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    pulse_d = 1'b1;
                    retry_d = retry_inc_s;
                    if (retry_inc_s >= RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_ASSERT_RST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READY: begin
                if (!link_ok_s) begin
                    state_d = ST_WAIT_PG;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_WAIT_PG;
            end
        endcase
    end

    // State, counter and outputs; outputs follow the state being entered so
    // they change in the same cycle as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_WAIT_PG;
            cnt_q          <= '0;
            retry_q        <= '0;
            gt_reset_all_q <= 1'b1;
            cmac_reset_q   <= 1'b1;
            gt_ready_q     <= 1'b0;
            pulse_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            gt_reset_all_q <= !((state_d == ST_WAIT_DONE) || (state_d == ST_READY));
            cmac_reset_q   <= (state_d != ST_READY);
            gt_ready_q     <= (state_d == ST_READY);
            pulse_q        <= pulse_d;
        end
    end

    assign gt_reset_all_out  = gt_reset_all_q;
    assign cmac_reset_out    = cmac_reset_q;
    assign gt_ready_out      = gt_ready_q;
    assign timeout_pulse_out = pulse_q;
    assign retry_count_out   = retry_q;
    assign state_out         = state_q;

endmodule

// File: doc/cmac_gt_reset_seq.md
Name: cmac_gt_reset_seq

Overview:
Free-running-clock reset sequencer for the CMAC GT quad.
- Consumes the GT power-good flag, the same one that gates the refclk BUFG_GT CE, plus the GT TX/RX reset-done flags.
- Holds the transceiver and CMAC in reset until power is stable, releases the GT reset-all, then waits for reset completion with timeout/retry.
- Sits directly downstream of the GT refclk buffer stage and upstream of the CMAC core reset inputs.

Parameters:
SYNC_STAGES, 2, flop depth of each input synchronizer (min 2)
SETTLE_CYCLES, 1024, clk cycles power-good must stay high before reset sequencing
RST_PULSE_CYCLES, 64, clk cycles gt_reset_all_out is held in ASSERT_RST
TIMEOUT_CYCLES, 1048576, clk cycles allowed in WAIT_DONE before a retry
MAX_RETRIES, 7, timeouts tolerated before entering FAIL (1..15)

Ports:
clk  input  1  free-running init/DRP clock; sole clock of the block
rst  input  1  synchronous, active-high reset
gt_powergood_in  input  1  GT power-good, asynchronous to clk
tx_reset_done_in  input  1  GT TX reset done, asynchronous
rx_reset_done_in  input  1  GT RX reset done, asynchronous
gt_reset_all_out  output  1  GT wizard reset-all, active high
cmac_reset_out  output  1  CMAC core reset, active high
gt_ready_out  output  1  link bring-up complete
timeout_pulse_out  output  1  one-cycle pulse per WAIT_DONE timeout
retry_count_out  output  4  saturating count of timeouts since rst
state_out  output  3  current FSM state encoding, for debug

Behaviour:
- All three async inputs pass through SYNC_STAGES-flop synchronizers. The FSM sees only the synchronized versions: pg_s, txd_s, rxd_s.
- All outputs are registered. Reset values on rst: gt_reset_all_out=1, cmac_reset_out=1, gt_ready_out=0, timeout_pulse_out=0, retry_count_out=0, state_out=WAIT_PG, cycle counter=0, synchronizers cleared to 0.
- Reset takes priority over every other event, including mid-sequence. The FSM returns to WAIT_PG on the cycle after rst is sampled high.
- Single cycle counter, width clog2(max(SETTLE_CYCLES, RST_PULSE_CYCLES, TIMEOUT_CYCLES))+1. It is cleared on every state transition.
- States and transitions:
  - WAIT_PG (0): resets asserted. pg_s=1 -> SETTLE on the next cycle.
  - SETTLE (1): resets asserted. pg_s=0 -> WAIT_PG. Counter reaching SETTLE_CYCLES-1 -> ASSERT_RST. Total residency is exactly SETTLE_CYCLES.
  - ASSERT_RST (2): gt_reset_all_out=1. After exactly RST_PULSE_CYCLES -> WAIT_DONE.
  - WAIT_DONE (3): gt_reset_all_out=0, cmac_reset_out=1.
    - txd_s & rxd_s -> READY.
    - Counter reaching TIMEOUT_CYCLES-1 without done -> timeout. timeout_pulse_out=1 for one cycle and retry_count_out increments (saturating at 15).
    - After a timeout: if the incremented count >= MAX_RETRIES -> FAIL, else -> ASSERT_RST.
    - If done and timeout occur in the same cycle, done wins: no pulse, no increment.
  - READY (4): gt_reset_all_out=0, cmac_reset_out=0, gt_ready_out=1. These outputs change the cycle the state register becomes READY. Loss of pg_s, txd_s or rxd_s -> WAIT_PG; resets reassert and gt_ready_out falls one cycle later.
  - FAIL (5): gt_reset_all_out=1, cmac_reset_out=1, gt_ready_out=0. Held until rst; power-good activity is ignored.
- pg_s=0 in SETTLE, ASSERT_RST, WAIT_DONE or READY -> WAIT_PG. This has priority over every other transition from those states.
- retry_count_out is cleared only by rst; it survives power-good loss.
- Encodings 6 and 7 are illegal and recover to WAIT_PG.
- Latency from a gt_powergood_in rise (stable) to gt_reset_all_out falling: SYNC_STAGES + 1 + SETTLE_CYCLES + RST_PULSE_CYCLES cycles, ±1 for async sampling.

Decomposition:
- Package cmac_gt_reset_pkg holds:
  - state typedef (3-bit enum: WAIT_PG, SETTLE, ASSERT_RST, WAIT_DONE, READY, FAIL);
  - retry-count width constant (4).
- Sub-module cdc_sync_bit (parameter SYNC_STAGES, with ASYNC_REG attributes), instantiated three times.

Test Plan:
All scenarios use SYNC_STAGES=2, SETTLE=16, RST_PULSE=8, TIMEOUT=64, MAX_RETRIES=2.
1. Nominal bring-up: raise powergood; raise tx/rx done 10 cycles after gt_reset_all_out falls -> gt_reset_all_out falls 27±1 cycles after the powergood rise; cmac_reset_out=0 and gt_ready_out=1 within 3 cycles of done; retry_count_out=0.
2. Powergood glitch during SETTLE: powergood high 8 cycles, low 4, then high -> state returns to WAIT_PG; the full 16-cycle settle restarts; no early reset release.
3. Single timeout then success: withhold done past 64 cycles, then supply it on the retry -> one timeout_pulse_out; retry_count_out=1; gt_reset_all_out re-asserted for 8 cycles; READY reached.
4. Persistent failure: never assert done -> two timeout pulses 72 cycles apart; state_out=5; all resets held; powergood toggling has no effect until rst.
5. Link loss in READY: drop rx_reset_done_in -> within SYNC_STAGES+2 cycles gt_ready_out=0, cmac_reset_out=1, state_out=WAIT_PG, then the sequence restarts.
6. Synchronous reset mid-WAIT_DONE with retry_count_out=1 -> next cycle state_out=0, retry_count_out=0, gt_reset_all_out=1; done arriving in the same cycle as a timeout gives READY with no pulse.
